// File: rtl/dcm_clkgen_prog_receiver.sv
// Receiver for the DCM_CLKGEN serial M/D programming port: deframes load-D/load-M/GO
// commands, range-checks the result and applies it. Optional M/D ratio check: DCM_PROG_RATIO_CHECK_EN.
module dcm_clkgen_prog_receiver #(
    parameter int M_DEFAULT    = 42,
    parameter int D_DEFAULT    = 25,
    parameter int DONE_LATENCY = 4
) (
    input  logic       okClk,
    input  logic       reset,
    input  logic       prog_en,
    input  logic       prog_data,
    output logic [8:0] m_value,
    output logic [8:0] d_value,
    output logic       prog_done,
    output logic       update_strobe,
    output logic       prog_error
);

    localparam int CNT_W = (DONE_LATENCY > 1) ? $clog2(DONE_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD2, S_SHIFT, S_GAP, S_APPLY, S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic [7:0]       sreg_q, sreg_d;
    logic [7:0]       pend_d_q, pend_d_d;
    logic [7:0]       pend_m_q, pend_m_d;
    logic             pend_d_vld_q, pend_d_vld_d;
    logic             pend_m_vld_q, pend_m_vld_d;
    logic [8:0]       m_q, m_d;
    logic [8:0]       d_q, d_d;
    logic             done_q, done_d;
    logic             strobe_q, strobe_d;
    logic             err_q, err_d;
    logic             go_err;
    logic [8:0]       eff_m, eff_d;

`ifdef DCM_PROG_RATIO_CHECK_EN
    // 0.05 <= M/D <= 3.33 evaluated without division.
    function automatic logic ratio_ok(input logic [8:0] m, input logic [8:0] d);
        return (13'(m) * 13'd20 >= 13'(d)) && (13'(m) * 13'd3 <= 13'(d) * 13'd10);
    endfunction
`endif

    function automatic logic range_ok(input logic m_loaded, input logic [7:0] m_minus1,
                                      input logic [8:0] m, input logic [8:0] d);
        logic ok;
        ok = !(m_loaded && (m_minus1 == 8'd0));
`ifdef DCM_PROG_RATIO_CHECK_EN
        ok = ok && ratio_ok(m, d);
`else
        ok = ok && (m != 9'd0 || d != 9'd0 || 1'b1);
`endif
        return ok;
    endfunction

    // Values that would be presented if the pending words were applied now.
    assign eff_m = pend_m_vld_q ? ({1'b0, pend_m_q} + 9'd1) : m_q;
    assign eff_d = pend_d_vld_q ? ({1'b0, pend_d_q} + 9'd1) : d_q;

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        cnt_d        = cnt_q;
        sel_d        = sel_q;
        sreg_d       = sreg_q;
        pend_d_d     = pend_d_q;
        pend_m_d     = pend_m_q;
        pend_d_vld_d = pend_d_vld_q;
        pend_m_vld_d = pend_m_vld_q;
        m_d          = m_q;
        d_d          = d_q;
        done_d       = done_q;
        strobe_d     = 1'b0;
        err_d        = err_q;
        go_err       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (prog_en) begin
                    done_d = 1'b0;
                    if (prog_data) begin
                        state_d = S_CMD2;
                    end else begin
                        state_d = S_APPLY;
                        cnt_d   = '0;
                    end
                end
            end
            S_CMD2: begin
                if (prog_en) begin
                    sel_d    = prog_data;
                    bitcnt_d = 3'd0;
                    state_d  = S_SHIFT;
                end else begin
                    go_err = 1'b1;
                end
            end
            S_SHIFT: begin
                if (prog_en) begin
                    sreg_d[bitcnt_q] = prog_data;
                    if (bitcnt_q == 3'd7) begin
                        state_d = S_GAP;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end else begin
                    go_err = 1'b1;
                end
            end
            S_GAP: begin
                if (prog_en) begin
                    go_err = 1'b1;
                end else begin
                    if (sel_q) begin
                        pend_m_d     = sreg_q;
                        pend_m_vld_d = 1'b1;
                    end else begin
                        pend_d_d     = sreg_q;
                        pend_d_vld_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            S_APPLY: begin
                if (prog_en) begin
                    go_err = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    if (range_ok(pend_m_vld_q, pend_m_q, eff_m, eff_d)) begin
                        m_d          = eff_m;
                        d_d          = eff_d;
                        strobe_d     = pend_m_vld_q | pend_d_vld_q;
                        done_d       = 1'b1;
                        err_d        = 1'b0;
                        pend_m_vld_d = 1'b0;
                        pend_d_vld_d = 1'b0;
                        state_d      = S_IDLE;
                    end else begin
                        go_err = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ERR: begin
                if (!prog_en) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Any framing or range fault drops the whole pending program.
        if (go_err) begin
            state_d      = S_ERR;
            err_d        = 1'b1;
            done_d       = 1'b1;
            pend_m_vld_d = 1'b0;
            pend_d_vld_d = 1'b0;
        end
    end

    always_ff @(posedge okClk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            bitcnt_q     <= 3'd0;
            cnt_q        <= '0;
            pend_d_vld_q <= 1'b0;
            pend_m_vld_q <= 1'b0;
            m_q          <= 9'(M_DEFAULT);
            d_q          <= 9'(D_DEFAULT);
            done_q       <= 1'b1;
            strobe_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            cnt_q        <= cnt_d;
            pend_d_vld_q <= pend_d_vld_d;
            pend_m_vld_q <= pend_m_vld_d;
            m_q          <= m_d;
            d_q          <= d_d;
            done_q       <= done_d;
            strobe_q     <= strobe_d;
            err_q        <= err_d;
        end
    end

    // Shift and pending words are qualified by the valid flags above.
    always_ff @(posedge okClk) begin
        sel_q    <= sel_d;
        sreg_q   <= sreg_d;
        pend_d_q <= pend_d_d;
        pend_m_q <= pend_m_d;
    end

    assign m_value       = m_q;
    assign d_value       = d_q;
    assign prog_done     = done_q;
    assign update_strobe = strobe_q;
    assign prog_error    = err_q;

endmodule

// File: tb/tb_dcm_clkgen_prog_receiver.sv
// Bench for dcm_clkgen_prog_receiver: directed scenarios plus random command streams
// checked against a transaction-level model of the programming port.
module tb_dcm_clkgen_prog_receiver;

    localparam int L = 4;

    logic       okClk = 1'b0;
    logic       reset = 1'b0;
    logic       prog_en = 1'b0;
    logic       prog_data = 1'b0;
    logic [8:0] m_value, d_value;
    logic       prog_done, update_strobe, prog_error;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: active values, flags, pending (M-1)/(D-1) words.
    int mm, md, mdone, merr;
    int pm, pd;
    bit pm_v, pd_v;

    dcm_clkgen_prog_receiver #(
        .M_DEFAULT(42), .D_DEFAULT(25), .DONE_LATENCY(L)
    ) dut (
        .okClk(okClk), .reset(reset), .prog_en(prog_en), .prog_data(prog_data),
        .m_value(m_value), .d_value(d_value), .prog_done(prog_done),
        .update_strobe(update_strobe), .prog_error(prog_error)
    );

    always #5 okClk = ~okClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_m"}, 32'(m_value), mm);
        check({tag, "_d"}, 32'(d_value), md);
        check({tag, "_done"}, 32'(prog_done), mdone);
        check({tag, "_err"}, 32'(prog_error), merr);
        check({tag, "_strobe"}, 32'(update_strobe), 0);
    endtask

    task automatic drive(input logic en, input logic dat);
        @(negedge okClk);
        prog_en   = en;
        prog_data = dat;
    endtask

    task automatic gap(input int n);
        repeat (n) drive(1'b0, 1'b0);
    endtask

    task automatic model_error();
        merr  = 1;
        mdone = 1;
        pm_v  = 0;
        pd_v  = 0;
    endtask

    task automatic do_reset();
        @(negedge okClk);
        reset = 1'b1; prog_en = 1'b0; prog_data = 1'b0;
        repeat (3) @(negedge okClk);
        reset = 1'b0;
        mm = 42; md = 25; mdone = 1; merr = 0; pm_v = 0; pd_v = 0;
    endtask

    task automatic load(input bit sel, input int v);
        logic [7:0] w;
        w = 8'(v);
        drive(1'b1, 1'b1);
        drive(1'b1, sel);
        for (int i = 0; i < 8; i++) drive(1'b1, w[i]);
        mdone = 0;
        if (sel) begin pm = v; pm_v = 1; end
        else     begin pd = v; pd_v = 1; end
    endtask

    // n enable cycles (1..9) then en drops before the word completes.
    task automatic bad_short(input int n);
        drive(1'b1, 1'b1);
        for (int i = 1; i < n; i++) drive(1'b1, 1'($urandom_range(0, 1)));
        model_error();
    endtask

    task automatic bad_long();
        drive(1'b1, 1'b1);
        for (int i = 1; i < 11; i++) drive(1'b1, 1'($urandom_range(0, 1)));
        model_error();
    endtask

    task automatic go(input string tag);
        int em, ed, old_m;
        bit ok, exp_strb;
        em = pm_v ? pm + 1 : mm;
        ed = pd_v ? pd + 1 : md;
        ok = !(pm_v && pm == 0);
`ifdef DCM_PROG_RATIO_CHECK_EN
        ok = ok && (20 * em >= ed) && (3 * em <= 10 * ed);
`endif
        old_m = mm;
        exp_strb = ok && (pm_v || pd_v);
        drive(1'b1, 1'b0);
        repeat (L) drive(1'b0, 1'b0);
        check({tag, "_early_strobe"}, 32'(update_strobe), 0);
        check({tag, "_early_done"}, 32'(prog_done), 0);
        check({tag, "_early_m"}, 32'(m_value), old_m);
        if (ok) begin
            mm = em; md = ed; merr = 0; mdone = 1; pm_v = 0; pd_v = 0;
        end else begin
            model_error();
        end
        drive(1'b0, 1'b0);
        check({tag, "_strobe"}, 32'(update_strobe), 32'(exp_strb));
        check({tag, "_m"}, 32'(m_value), mm);
        check({tag, "_d"}, 32'(d_value), md);
        check({tag, "_done"}, 32'(prog_done), mdone);
        gap(2);
        check_state({tag, "_after"});
    endtask

    initial begin
        do_reset();
        check_state("reset");

        load(1'b0, 8'h7C); gap(5);
        check_state("ld_d125");
        load(1'b1, 8'h06); gap(5);
        go("go_7_125");

        bad_short(7); gap(3);
        check_state("short_d");
        load(1'b0, 13); gap(2); load(1'b1, 4); gap(2);
        go("go_5_14");

        bad_long(); gap(3);
        check_state("long_m");
        go("go_after_long");

        load(1'b1, 0); gap(2);
        go("go_m1");

        load(1'b1, 255); gap(2); load(1'b0, 1); gap(2);
        go("go_256_2");

        // GO interrupted by enable during the latency window.
        load(1'b1, 8); gap(2);
        drive(1'b1, 1'b0); drive(1'b1, 1'b0);
        model_error();
        gap(3);
        check_state("go_abort");

        // Reset in the middle of a word discards everything.
        load(1'b1, 20); gap(2);
        drive(1'b1, 1'b1); drive(1'b1, 1'b0);
        drive(1'b1, 1'b1); drive(1'b1, 1'b0);
        do_reset();
        check_state("mid_reset");
        go("go_post_reset");

        for (int k = 0; k < 80; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 30)      load(1'b0, (($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 255)));
            else if (r < 60) load(1'b1, (($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255)));
            else if (r < 85) begin
                go("rnd_go");
                continue;
            end
            else if (r < 93) bad_short($urandom_range(1, 9));
            else             bad_long();
            gap($urandom_range(2, 5));
            check_state("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
